// File: rtl/scan_bist_controller_if.sv
// scan_bist_controller_if
//   Groups the BIST session control, the CUT scan handshake and the status
//   outputs of scan_bist_controller into one bundle.
//   master : test access side / CUT wrapper (drives START, ABORT, SO)
//   slave  : the controller (drives SE, LFSR_LOAD, LFSR_EN, status, SIGNATURE, PAT_CNT)
interface scan_bist_controller_if #(
    parameter int SIG_W = 16,
    parameter int CNT_W = 6
);
    logic             START;
    logic             ABORT;
    logic             SO;
    logic             SE;
    logic             LFSR_LOAD;
    logic             LFSR_EN;
    logic             BUSY;
    logic             DONE;
    logic             PASS;
    logic [SIG_W-1:0] SIGNATURE;
    logic [CNT_W-1:0] PAT_CNT;

    modport master (
        output START, ABORT, SO,
        input  SE, LFSR_LOAD, LFSR_EN, BUSY, DONE, PASS, SIGNATURE, PAT_CNT
    );

    modport slave (
        input  START, ABORT, SO,
        output SE, LFSR_LOAD, LFSR_EN, BUSY, DONE, PASS, SIGNATURE, PAT_CNT
    );
endinterface

// File: rtl/scan_bist_controller.sv
// scan_bist_controller
//   Runs a scan BIST session: seeds the pattern LFSR, then for each pattern
//   shifts CHAIN_LEN cycles (SE=1, LFSR advancing) and captures one cycle
//   (SE=0). A final CHAIN_LEN-cycle unload flushes the last response. SO is
//   compacted into a MISR on every shift cycle except during the first load,
//   whose scan-out is unknown. PASS compares the final signature to GOLDEN_SIG.
// Ports:
//   CLK   - clock, rising edge
//   RST_N - asynchronous active-low reset
//   bus   - slave side of scan_bist_controller_if (START/ABORT/SO in,
//           SE/LFSR_LOAD/LFSR_EN/BUSY/DONE/PASS/SIGNATURE/PAT_CNT out)
// Every output is a register or a decode of the registered state.
module scan_bist_controller #(
    parameter int               CHAIN_LEN    = 4,
    parameter int               NUM_PATTERNS = 32,
    parameter int               CNT_W        = 6,
    parameter int               SIG_W        = 16,
    parameter logic [SIG_W-1:0] POLY         = 16'h1021,
    parameter logic [SIG_W-1:0] GOLDEN_SIG   = 16'h0000
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    scan_bist_controller_if.slave bus
);

    localparam int SC_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_SHIFT,
        S_CAPTURE,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [SC_W-1:0]  sh_cnt;
    logic [CNT_W-1:0] pat_cnt;
    logic [CNT_W:0]   pat_inc;
    logic [SIG_W-1:0] sig, misr_nxt;
    logic             pass;
    logic             sh_last, pat_last, pat_sat, compact;
    logic             se, lfsr_load, lfsr_en, busy, done;

    assign sh_last  = (sh_cnt == SC_W'(CHAIN_LEN - 1));
    assign pat_inc  = {1'b0, pat_cnt} + 1'b1;
    assign pat_last = (pat_inc == (CNT_W+1)'(NUM_PATTERNS));
    assign pat_sat  = ({1'b0, pat_cnt} >= (CNT_W+1)'(NUM_PATTERNS));

    // The first load's scan-out is whatever the CUT held before the session,
    // so shifting is only compacted once at least one pattern was captured.
    assign compact  = ((state == S_SHIFT) && (pat_cnt != '0)) || (state == S_UNLOAD);
    assign misr_nxt = {sig[SIG_W-2:0], 1'b0} ^ ({SIG_W{sig[SIG_W-1] ^ bus.SO}} & POLY);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        se        = 1'b0;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.START) state_nxt = S_SEED;
            end
            S_SEED: begin
                lfsr_load = 1'b1;
                busy      = 1'b1;
                state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                se      = 1'b1;
                lfsr_en = 1'b1;
                busy    = 1'b1;
                if (sh_last) state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                busy      = 1'b1;
                state_nxt = pat_last ? S_UNLOAD : S_SHIFT;
            end
            S_UNLOAD: begin
                se   = 1'b1;
                busy = 1'b1;
                if (sh_last) state_nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (bus.START) state_nxt = S_SEED;
            end
            default: state_nxt = S_IDLE;
        endcase
        // Abort wins over START and over any pending transition.
        if (bus.ABORT) state_nxt = S_IDLE;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sig     <= '0;
            pat_cnt <= '0;
            sh_cnt  <= '0;
            pass    <= 1'b0;
        end else if (bus.ABORT) begin
            sig     <= '0;
            pat_cnt <= '0;
            sh_cnt  <= '0;
            pass    <= 1'b0;
        end else begin
            case (state)
                // Clear on the way into SEED so PASS/SIGNATURE already read 0 there.
                S_IDLE, S_DONE: begin
                    if (bus.START) begin
                        sig     <= '0;
                        pat_cnt <= '0;
                        sh_cnt  <= '0;
                        pass    <= 1'b0;
                    end
                end
                S_SEED: begin
                    sig     <= '0;
                    pat_cnt <= '0;
                    sh_cnt  <= '0;
                end
                S_SHIFT: begin
                    if (compact) sig <= misr_nxt;
                    sh_cnt <= sh_last ? '0 : sh_cnt + 1'b1;
                end
                S_CAPTURE: begin
                    if (!pat_sat) pat_cnt <= pat_inc[CNT_W-1:0];
                end
                S_UNLOAD: begin
                    sig    <= misr_nxt;
                    sh_cnt <= sh_last ? '0 : sh_cnt + 1'b1;
                    // Judge against the signature that DONE will display.
                    if (sh_last) pass <= (misr_nxt == GOLDEN_SIG);
                end
                default: ;
            endcase
        end
    end

    assign bus.SE        = se;
    assign bus.LFSR_LOAD = lfsr_load;
    assign bus.LFSR_EN   = lfsr_en;
    assign bus.BUSY      = busy;
    assign bus.DONE      = done;
    assign bus.PASS      = pass;
    assign bus.SIGNATURE = sig;
    assign bus.PAT_CNT   = pat_cnt;

endmodule

// File: tb/tb_scan_bist_controller.sv
// Directed bench for scan_bist_controller: default build (4-bit chain,
// 32 patterns) plus a single-pattern build for the NUM_PATTERNS=1 corner.
module tb_scan_bist_controller;

    localparam logic [15:0] POLY   = 16'h1021;
    localparam logic [15:0] GOLDEN = 16'h0000;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    scan_bist_controller_if #(.SIG_W(16), .CNT_W(6)) bus ();
    scan_bist_controller #(
        .CHAIN_LEN(4), .NUM_PATTERNS(32), .CNT_W(6), .SIG_W(16),
        .POLY(16'h1021), .GOLDEN_SIG(16'h0000)
    ) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus.slave));

    scan_bist_controller_if #(.SIG_W(16), .CNT_W(2)) bus1 ();
    scan_bist_controller #(
        .CHAIN_LEN(4), .NUM_PATTERNS(1), .CNT_W(2), .SIG_W(16),
        .POLY(16'h1021), .GOLDEN_SIG(16'h0000)
    ) dut1 (.CLK(CLK), .RST_N(RST_N), .bus(bus1.slave));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] misr(input logic [15:0] s, input logic so);
        return {s[14:0], 1'b0} ^ ({16{s[15] ^ so}} & POLY);
    endfunction

    task automatic check_idle(input string name);
        chk(name, 64'({bus.SE, bus.LFSR_LOAD, bus.LFSR_EN, bus.BUSY, bus.DONE,
                       bus.PASS, bus.SIGNATURE, bus.PAT_CNT}), 64'd0);
    endtask

    // k = clock edges after the START sampling edge (k=0 is the SEED cycle).
    typedef struct {
        int   k;
        logic [4:0] ctl;   // {SE, LFSR_LOAD, LFSR_EN, BUSY, DONE}
        bit   cp;          // compare PASS against 0
        int   pat;
    } vec_t;
    vec_t tbl[12];

    // Runs one 32-pattern session; caller is at a negedge. SO pattern by mode:
    // 0 all zero, 1 only first UNLOAD cycle, 2 only pattern-0 shift, 3 random.
    task automatic run_session(input int mode, input bit hold_start, input string tag,
                               output logic [15:0] model);
        int   se_err, done_k, p, ph;
        logic so, exp_se;
        bit   comp;
        model  = '0;
        se_err = 0;
        done_k = -1;
        bus.START = 1'b1;
        bus.SO    = 1'b0;
        @(posedge CLK);
        for (int k = 0; k <= 166; k++) begin
            @(negedge CLK);
            if (!hold_start || k == 165) bus.START = 1'b0;
            comp = 1'b0;
            if (k == 0) exp_se = 1'b0;
            else if (k <= 160) begin
                p = (k - 1) / 5;
                ph = (k - 1) % 5;
                exp_se = (ph < 4);
                comp = (ph < 4) && (p >= 1);
            end else if (k <= 164) begin
                exp_se = 1'b1;
                comp = 1'b1;
            end else exp_se = 1'b0;
            if (bus.SE !== exp_se) se_err++;
            if (bus.DONE === 1'b1 && done_k < 0) done_k = k;
            for (int i = 0; i < 12; i++) begin
                if (tbl[i].k == k) begin
                    chk($sformatf("%s_k%0d_ctl", tag, k),
                        64'({bus.SE, bus.LFSR_LOAD, bus.LFSR_EN, bus.BUSY, bus.DONE}),
                        64'(tbl[i].ctl));
                    chk($sformatf("%s_k%0d_pat", tag, k), 64'(bus.PAT_CNT), 64'(tbl[i].pat));
                    if (tbl[i].cp) chk($sformatf("%s_k%0d_pass", tag, k), 64'(bus.PASS), 64'd0);
                end
            end
            case (mode)
                1:       so = (k == 161);
                2:       so = (k >= 1 && k <= 4);
                3:       so = 1'($urandom_range(1, 0));
                default: so = 1'b0;
            endcase
            bus.SO = so;
            if (comp) model = misr(model, so);
        end
        bus.SO = 1'b0;
        chk({tag, "_se_wave_errs"}, 64'(se_err), 64'd0);
        chk({tag, "_done_cycle"}, 64'(done_k), 64'd165);
        chk({tag, "_sig"}, 64'(bus.SIGNATURE), 64'(model));
        chk({tag, "_pass"}, 64'(bus.PASS), 64'(model == GOLDEN));
        chk({tag, "_pat_final"}, 64'(bus.PAT_CNT), 64'd32);
    endtask

    initial begin
        logic [15:0] m;
        int done_k, se_err;

        tbl[0]  = '{0,   5'b01010, 1'b1, 0};
        tbl[1]  = '{1,   5'b10110, 1'b1, 0};
        tbl[2]  = '{4,   5'b10110, 1'b1, 0};
        tbl[3]  = '{5,   5'b00010, 1'b1, 0};
        tbl[4]  = '{6,   5'b10110, 1'b1, 1};
        tbl[5]  = '{10,  5'b00010, 1'b1, 1};
        tbl[6]  = '{11,  5'b10110, 1'b1, 2};
        tbl[7]  = '{160, 5'b00010, 1'b1, 31};
        tbl[8]  = '{161, 5'b10010, 1'b1, 32};
        tbl[9]  = '{164, 5'b10010, 1'b1, 32};
        tbl[10] = '{165, 5'b00001, 1'b0, 32};
        tbl[11] = '{166, 5'b00001, 1'b0, 32};

        bus.START = 0; bus.ABORT = 0; bus.SO = 0;
        bus1.START = 0; bus1.ABORT = 0; bus1.SO = 0;
        repeat (2) @(negedge CLK);
        check_idle("reset");
        RST_N = 1'b1;
        @(negedge CLK);
        check_idle("idle");

        run_session(0, 1'b0, "s0", m);
        chk("s0_sig_const", 64'(bus.SIGNATURE), 64'h0000);
        chk("s0_pass_const", 64'(bus.PASS), 64'd1);

        run_session(1, 1'b0, "s1", m);
        chk("s1_sig_const", 64'(bus.SIGNATURE), 64'h8108);
        chk("s1_pass_const", 64'(bus.PASS), 64'd0);

        run_session(2, 1'b0, "s2", m);
        chk("s2_sig_const", 64'(bus.SIGNATURE), 64'h0000);

        // Abort mid-session, with random SO so the MISR is busy when it hits.
        bus.START = 1'b1;
        @(posedge CLK);
        for (int k = 0; k <= 50; k++) begin
            @(negedge CLK);
            bus.START = 1'b0;
            bus.SO = 1'($urandom_range(1, 0));
            if (k == 50) bus.ABORT = 1'b1;
        end
        @(negedge CLK);
        bus.ABORT = 1'b0;
        bus.SO = 1'b0;
        check_idle("abort_idle");
        run_session(0, 1'b0, "post_abort", m);

        // Reset mid-SHIFT with START held high the whole time.
        bus.START = 1'b1;
        @(posedge CLK);
        repeat (12) @(negedge CLK);
        RST_N = 1'b0;
        #1 check_idle("rst_async");
        @(negedge CLK);
        check_idle("rst_held");
        RST_N = 1'b1;
        run_session(2, 1'b1, "post_rst", m);

        // Restart from DONE (PASS=1) with random SO; table checks PASS clears in SEED.
        run_session(3, 1'b0, "restart", m);

        // Single-pattern build: SO=1 always, only UNLOAD compacts.
        m = '0; done_k = -1; se_err = 0;
        bus1.SO = 1'b1;
        bus1.START = 1'b1;
        @(posedge CLK);
        for (int k = 0; k <= 11; k++) begin
            @(negedge CLK);
            bus1.START = 1'b0;
            if (bus1.SE !== ((k >= 1 && k <= 4) || (k >= 6 && k <= 9))) se_err++;
            if (bus1.DONE === 1'b1 && done_k < 0) done_k = k;
            if (k >= 6 && k <= 9) m = misr(m, 1'b1);
        end
        bus1.SO = 1'b0;
        chk("np1_se_wave_errs", 64'(se_err), 64'd0);
        chk("np1_done_cycle", 64'(done_k), 64'd10);
        chk("np1_sig", 64'(bus1.SIGNATURE), 64'(m));
        chk("np1_pat", 64'(bus1.PAT_CNT), 64'd1);
        chk("np1_pass", 64'(bus1.PASS), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_bist_controller.md
Name: scan_bist_controller

Overview:
Sequences a scan-based BIST session on the LFSR-fed scan chain of the circuit under test. It drives SE through repeated shift/capture windows for a programmable number of patterns and steps the pattern LFSR. It compacts the serial scan-out SO into a MISR signature and reports pass/fail against a golden signature. It replaces bench-driven SE sequencing and sits between the test access logic and the CUT wrapper.

Parameters:
CHAIN_LEN, 4, scan chain length (shift cycles per pattern), >=1
NUM_PATTERNS, 32, patterns applied per session, >=1
CNT_W, 6, width of pattern counter, must hold NUM_PATTERNS
SIG_W, 16, MISR/signature width
POLY, 16'h1021, MISR feedback polynomial (SIG_W bits)
GOLDEN_SIG, 16'h0000, expected final signature

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
START  in  1  begin session (sampled in IDLE and DONE)
ABORT  in  1  synchronous abort, returns to IDLE
SO  in  1  scan-out from CUT
SE  out  1  scan enable to CUT (1 = shift, 0 = capture/functional)
LFSR_LOAD  out  1  load pattern LFSR seed
LFSR_EN  out  1  advance pattern LFSR
BUSY  out  1  session in progress
DONE  out  1  session complete
PASS  out  1  SIGNATURE == GOLDEN_SIG, valid when DONE=1
SIGNATURE  out  SIG_W  current MISR contents
PAT_CNT  out  CNT_W  patterns captured so far

Behaviour:
- One clock CLK; reset is asynchronous and active-low (RST_N). Reset forces: state=IDLE, SE=0, LFSR_LOAD=0, LFSR_EN=0, BUSY=0, DONE=0, PASS=0, SIGNATURE=0, PAT_CNT=0, shift counter=0.
- All outputs are registered or decoded from registered state only. No combinational path from inputs to outputs.
- FSM states: IDLE, SEED, SHIFT, CAPTURE, UNLOAD, DONE.
- IDLE: all outputs at reset values. START=1 -> SEED.
- SEED (1 cycle):
  - LFSR_LOAD=1, BUSY=1.
  - SIGNATURE, PAT_CNT and shift counter cleared.
  - -> SHIFT.
- SHIFT (exactly CHAIN_LEN cycles):
  - SE=1, LFSR_EN=1, BUSY=1.
  - MISR compacts SO each cycle only when PAT_CNT>=1; the first load's scan-out is unknown and is not compacted.
  - Last cycle -> CAPTURE.
- CAPTURE (1 cycle):
  - SE=0, LFSR_EN=0, no compaction.
  - PAT_CNT increments.
  - If the incremented value == NUM_PATTERNS -> UNLOAD, else -> SHIFT.
- UNLOAD (CHAIN_LEN cycles):
  - SE=1, LFSR_EN=0, MISR compacts SO every cycle.
  - -> DONE.
- DONE:
  - DONE=1, BUSY=0, SE=0.
  - PASS registered on entry as (final SIGNATURE == GOLDEN_SIG).
  - SIGNATURE and PAT_CNT hold.
  - START=1 -> SEED (restart; DONE and PASS clear in SEED).
- MISR update: sig <= {sig[SIG_W-2:0],1'b0} ^ ({SIG_W{sig[SIG_W-1]^SO}} & POLY).
- Session length from START sample to DONE=1: 1 + NUM_PATTERNS*(CHAIN_LEN+1) + CHAIN_LEN cycles. Defaults: 165.
- Compaction cycles per session: NUM_PATTERNS*CHAIN_LEN. Defaults: 128.
- PAT_CNT saturates at NUM_PATTERNS; no wrap.
- ABORT=1 in any state other than IDLE:
  - Next cycle is IDLE with all outputs at reset values.
  - ABORT takes priority over START and over any state transition in the same cycle.
- START asserted while BUSY=1 is ignored.
- RST_N low mid-session: immediate return to reset values, no partial PASS.
- NUM_PATTERNS=1: SEED, SHIFT, CAPTURE, UNLOAD, DONE; only UNLOAD cycles compact.

Test Plan:
- Reset then START pulse with SO tied 0 -> SE waveform 0,(1x4,0)x32,1x4,0; DONE at cycle 165 after START sample; SIGNATURE=16'h0000; PASS=1; PAT_CNT=32.
- SO=1 only on the first UNLOAD cycle, else 0 -> exactly one nonzero compaction; SIGNATURE = 16'h1021 shifted by the remaining 3 cycles (model-checked); PASS=0.
- SO=1 during SHIFT of pattern 0 only -> SIGNATURE=0 (not compacted); PASS=1.
- ABORT at cycle 50 -> next cycle IDLE, SE=0, BUSY=0, SIGNATURE=0, PAT_CNT=0; a later START runs a full 165-cycle session.
- RST_N low mid-SHIFT, then START held high throughout -> all outputs 0 during reset; a new session starts cleanly after release; START during BUSY causes no restart.
- From DONE, START again with random SO against a reference model MISR -> SIGNATURE matches model; DONE clears in SEED; PASS is recomputed.
